// File: rtl/rv32_pkg.sv
// Shared RV32 fetch definitions: machine width, canonical NOP, default reset
// PC and the instruction+PC packet carried through the fetch queues.
package rv32_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSN_DEFAULT = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] insn;
    logic [XLEN-1:0] pc;
  } fetch_pkt_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch packets with a combinational head view,
// a single-cycle flush and an occupancy count.
module fetch_queue
  import rv32_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  fetch_pkt_t       push_data,
  input  logic             pop,
  output fetch_pkt_t       head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  fetch_pkt_t       mem_reg [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [DEPTH-1:0] slot_we;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full queue may still take a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem_reg[rd_ptr_reg];
  assign count   = count_reg;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_we
    assign slot_we[gi] = do_push && (wr_ptr_reg == PTR_W'(gi));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_we[i]) begin
        mem_reg[i] <= push_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (do_pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32 instruction-fetch stage: credit-limited word requests, in-order
// response queue with PC tags, one instruction per cycle to decode.
module fetch_stage
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int              BUF_DEPTH = 2,
  parameter logic [XLEN-1:0] NOP_INSN  = NOP_INSN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic [XLEN-1:0] ins_fetch_out,
  output logic [XLEN-1:0] pc_fetch_out,
  output logic            ins_valid
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(BUF_DEPTH);

  logic [XLEN-1:0]  pc_reg, pc_next;
  logic [CNT_W-1:0] outstanding_reg, outstanding_next;
  logic [CNT_W-1:0] drop_cnt_reg, drop_cnt_next;
  logic [XLEN-1:0]  ins_reg, ins_next;
  logic [XLEN-1:0]  pc_out_reg, pc_out_next;
  logic             valid_reg, valid_next;

  logic             accept;
  logic             resp;
  logic             resp_drop;
  logic             resp_keep;
  logic             bypass;
  logic             q_push, q_pop, q_empty, q_full;
  logic             t_empty, t_full;
  logic [CNT_W-1:0] q_count, t_count;
  logic [CNT_W:0]   credit_used;
  fetch_pkt_t       q_head, q_in, t_head, t_in;
  logic             unused_sigs;

  // Requests in flight plus buffered words never exceed the queue depth,
  // so every response always has a slot waiting for it.
  assign credit_used = {1'b0, outstanding_reg} + {1'b0, q_count};
  assign imem_req    = rst && (credit_used < CREDIT_MAX) && !redirect_en;
  assign imem_addr   = pc_reg;
  assign accept      = imem_req && imem_ready;

  // A response with nothing outstanding is a leftover from before reset.
  assign resp      = imem_rvalid && (outstanding_reg != '0);
  assign resp_drop = resp && (drop_cnt_reg != '0);
  assign resp_keep = resp && (drop_cnt_reg == '0) && !redirect_en;
  assign bypass    = resp_keep && q_empty && !stall;
  assign q_push    = resp_keep && !bypass;
  assign q_pop     = !redirect_en && !stall && !q_empty;

  assign q_in = '{insn: imem_rdata, pc: t_head.pc};
  assign t_in = '{insn: '0, pc: pc_reg};

  fetch_queue #(.DEPTH(BUF_DEPTH)) u_insn_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_en),
    .push      (q_push),
    .push_data (q_in),
    .pop       (q_pop),
    .head      (q_head),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full)
  );

  // Tags of live (not-to-be-dropped) requests, in issue order.
  fetch_queue #(.DEPTH(BUF_DEPTH)) u_tag_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_en),
    .push      (accept),
    .push_data (t_in),
    .pop       (resp_keep),
    .head      (t_head),
    .count     (t_count),
    .empty     (t_empty),
    .full      (t_full)
  );

  assign unused_sigs = &{1'b0, q_full, t_full, t_empty, t_count, t_head.insn};

  always_comb begin
    pc_next          = pc_reg;
    outstanding_next = outstanding_reg + CNT_W'(accept) - CNT_W'(resp);
    drop_cnt_next    = drop_cnt_reg - CNT_W'(resp_drop);
    ins_next         = ins_reg;
    pc_out_next      = pc_out_reg;
    valid_next       = valid_reg;

    if (accept) begin
      pc_next = pc_reg + 32'd4;
    end

    if (redirect_en) begin
      // Everything still in flight after this cycle belongs to the old path.
      pc_next       = word_align(redirect_pc);
      drop_cnt_next = outstanding_next;
      ins_next      = NOP_INSN;
      valid_next    = 1'b0;
    end else if (!stall) begin
      if (!q_empty) begin
        ins_next    = q_head.insn;
        pc_out_next = q_head.pc;
        valid_next  = 1'b1;
      end else if (bypass) begin
        ins_next    = imem_rdata;
        pc_out_next = t_head.pc;
        valid_next  = 1'b1;
      end else begin
        ins_next    = NOP_INSN;
        valid_next  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_reg          <= RESET_PC;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
      ins_reg         <= NOP_INSN;
      pc_out_reg      <= '0;
      valid_reg       <= 1'b0;
    end else begin
      pc_reg          <= pc_next;
      outstanding_reg <= outstanding_next;
      drop_cnt_reg    <= drop_cnt_next;
      ins_reg         <= ins_next;
      pc_out_reg      <= pc_out_next;
      valid_reg       <= valid_next;
    end
  end

  assign ins_fetch_out = ins_reg;
  assign pc_fetch_out  = pc_out_reg;
  assign ins_valid     = valid_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: an in-order memory model with programmable
// wait states and latency feeds the fetch port; each task checks one scenario.
`timescale 1ns/1ps
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] ins_fetch_out;
  logic [31:0] pc_fetch_out;
  logic        ins_valid;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0), .BUF_DEPTH(2), .NOP_INSN(NOP)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_en   (redirect_en),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .ins_fetch_out (ins_fetch_out),
    .pc_fetch_out  (pc_fetch_out),
    .ins_valid     (ins_valid)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  int          lat = 1;
  int          cyc = 0;
  int          out_cnt = 0;
  logic        rv_model = 1'b0;
  logic        acc_seen = 1'b0;
  logic [31:0] acc_addr = 32'h0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h0010_0113;
      default: return {8'hA5, a[23:0]};
    endcase
  endfunction

  // One clock of the memory model; returns #1 after the edge.
  task automatic step();
    logic rv_now;
    #1;
    acc_seen = imem_req && imem_ready;
    acc_addr = imem_addr;
    rv_now   = rv_model;
    @(posedge clk);
    #1;
    cyc++;
    if (acc_seen) begin
      pend_addr.push_back(acc_addr);
      pend_due.push_back(cyc + lat - 1);
      out_cnt++;
    end
    if (rv_now) out_cnt--;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_at(pend_addr[0]);
      rv_model    = 1'b1;
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      rv_model    = 1'b0;
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0; stall = 1'b0; redirect_en = 1'b0; redirect_pc = 32'h0; imem_ready = 1'b1;
    for (int i = 0; i < cycles; i++) step();
    pend_addr.delete(); pend_due.delete();
    out_cnt = 0; rv_model = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    rst = 1'b0; imem_ready = 1'b1; stall = 1'b0; redirect_en = 1'b0;
    redirect_pc = 32'h0; imem_rvalid = 1'b0; imem_rdata = 32'h0; lat = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (imem_req !== 1'b0) begin
        n_fail++; $display("FAIL reset_req: imem_req=%b required 0", imem_req);
      end
    end
    n_checks++;
    if (ins_fetch_out !== NOP || pc_fetch_out !== 32'h0 || ins_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: ins=%h pc=%h v=%b required %h/0/0", ins_fetch_out, pc_fetch_out, ins_valid, NOP);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_first_req: req=%b addr=%h required 1/0", imem_req, imem_addr);
    end
    step();
    n_checks++;
    if (ins_valid !== 1'b0 || acc_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_latency: v=%b acc=%h required 0/0", ins_valid, acc_addr);
    end
    step();
    n_checks++;
    if (ins_fetch_out !== 32'h0050_0093 || pc_fetch_out !== 32'h0 || ins_valid !== 1'b1 || acc_addr !== 32'h4) begin
      n_fail++;
      $display("FAIL reset_insn0: ins=%h pc=%h v=%b acc=%h required 00500093/0/1/4", ins_fetch_out, pc_fetch_out, ins_valid, acc_addr);
    end
    step();
    n_checks++;
    if (ins_fetch_out !== 32'h0010_0113 || pc_fetch_out !== 32'h4 || ins_valid !== 1'b1 || acc_addr !== 32'h8) begin
      n_fail++;
      $display("FAIL reset_insn1: ins=%h pc=%h v=%b acc=%h required 00100113/4/1/8", ins_fetch_out, pc_fetch_out, ins_valid, acc_addr);
    end
    exp_pc = 32'h8;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (ins_valid !== 1'b1 || pc_fetch_out !== exp_pc || ins_fetch_out !== word_at(exp_pc)) begin
        n_fail++;
        $display("FAIL stream: ins=%h pc=%h v=%b required %h/%h/1", ins_fetch_out, pc_fetch_out, ins_valid, word_at(exp_pc), exp_pc);
      end
      exp_pc += 32'h4;
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] exp_pc;
    int          bubbles;
    lat = 3;
    do_reset(2);
    exp_pc = 32'h0; bubbles = 0;
    for (int k = 0; k < 40; k++) begin
      imem_ready = ((k % 4) >= 2);
      step();
      n_checks++;
      if (out_cnt > 2) begin
        n_fail++; $display("FAIL credit: outstanding=%0d required <=2", out_cnt);
      end
      n_checks++;
      if (ins_valid === 1'b1) begin
        if (pc_fetch_out !== exp_pc || ins_fetch_out !== word_at(exp_pc)) begin
          n_fail++;
          $display("FAIL wait_order: ins=%h pc=%h required %h/%h", ins_fetch_out, pc_fetch_out, word_at(exp_pc), exp_pc);
        end
        exp_pc += 32'h4;
      end else begin
        bubbles++;
        if (ins_fetch_out !== NOP) begin
          n_fail++; $display("FAIL wait_bubble: ins=%h required %h", ins_fetch_out, NOP);
        end
      end
    end
    imem_ready = 1'b1;
    n_checks++;
    if (exp_pc < 32'h10 || bubbles == 0) begin
      n_fail++; $display("FAIL wait_progress: next_pc=%h bubbles=%0d required >=10 and >0", exp_pc, bubbles);
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc;
    lat = 1;
    do_reset(2);
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if (pc_fetch_out !== 32'h8 || ins_valid !== 1'b1) begin
      n_fail++; $display("FAIL stall_pre: pc=%h v=%b required 8/1", pc_fetch_out, ins_valid);
    end
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (pc_fetch_out !== 32'h8 || ins_fetch_out !== word_at(32'h8) || ins_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold: ins=%h pc=%h v=%b required %h/8/1", ins_fetch_out, pc_fetch_out, ins_valid, word_at(32'h8));
      end
      if (i >= 1) begin
        n_checks++;
        if (imem_req !== 1'b0) begin
          n_fail++; $display("FAIL stall_credit: imem_req=%b required 0", imem_req);
        end
      end
    end
    stall = 1'b0;
    exp_pc = 32'hC;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (ins_valid !== 1'b1 || pc_fetch_out !== exp_pc || ins_fetch_out !== word_at(exp_pc)) begin
        n_fail++;
        $display("FAIL stall_resume: ins=%h pc=%h v=%b required %h/%h/1", ins_fetch_out, pc_fetch_out, ins_valid, word_at(exp_pc), exp_pc);
      end
      exp_pc += 32'h4;
    end
  endtask

  task automatic test_redirect();
    int   nvalid;
    logic first_acc;
    // Two requests in flight, then redirect to 0x100.
    lat = 3;
    do_reset(2);
    step(); step();
    n_checks++;
    if (out_cnt !== 2) begin
      n_fail++; $display("FAIL redir_inflight: outstanding=%0d required 2", out_cnt);
    end
    redirect_en = 1'b1; redirect_pc = 32'h0000_0100;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++; $display("FAIL redir_noreq: imem_req=%b required 0", imem_req);
    end
    step();
    redirect_en = 1'b0;
    nvalid = 0; first_acc = 1'b1;
    for (int i = 0; i < 30 && nvalid < 2; i++) begin
      step();
      if (acc_seen && first_acc) begin
        first_acc = 1'b0;
        n_checks++;
        if (acc_addr !== 32'h100) begin
          n_fail++; $display("FAIL redir_addr: first addr=%h required 100", acc_addr);
        end
      end
      n_checks++;
      if (ins_valid === 1'b1) begin
        if (pc_fetch_out !== 32'h100 + 32'(nvalid * 4) || ins_fetch_out !== word_at(32'h100 + 32'(nvalid * 4))) begin
          n_fail++;
          $display("FAIL redir_target: ins=%h pc=%h required pc=%h", ins_fetch_out, pc_fetch_out, 32'h100 + 32'(nvalid * 4));
        end
        nvalid++;
      end else if (ins_fetch_out !== NOP) begin
        n_fail++; $display("FAIL redir_bubble: ins=%h required %h", ins_fetch_out, NOP);
      end
    end
    n_checks++;
    if (nvalid < 2) begin
      n_fail++; $display("FAIL redir_timeout: valid count=%0d required 2", nvalid);
    end
    // Redirect during a stall must still clear the held instruction.
    lat = 1;
    do_reset(2);
    for (int i = 0; i < 4; i++) step();
    stall = 1'b1;
    step();
    n_checks++;
    if (ins_valid !== 1'b1 || pc_fetch_out !== 32'h8) begin
      n_fail++; $display("FAIL redir_stall_pre: pc=%h v=%b required 8/1", pc_fetch_out, ins_valid);
    end
    redirect_en = 1'b1; redirect_pc = 32'h0000_0180;
    step();
    n_checks++;
    if (ins_valid !== 1'b0 || ins_fetch_out !== NOP) begin
      n_fail++; $display("FAIL redir_over_stall: ins=%h v=%b required %h/0", ins_fetch_out, ins_valid, NOP);
    end
    redirect_en = 1'b0; stall = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 20 && nvalid == 0; i++) begin
      step();
      if (ins_valid === 1'b1) begin
        nvalid++;
        n_checks++;
        if (pc_fetch_out !== 32'h180 || ins_fetch_out !== word_at(32'h180)) begin
          n_fail++; $display("FAIL redir_stall_target: ins=%h pc=%h required %h/180", ins_fetch_out, pc_fetch_out, word_at(32'h180));
        end
      end
    end
    n_checks++;
    if (nvalid == 0) begin
      n_fail++; $display("FAIL redir_stall_timeout: no valid instruction within 20 cycles");
    end
  endtask

  task automatic test_back_to_back();
    int   nvalid;
    logic first_acc;
    lat = 2;
    do_reset(2);
    step(); step(); step();
    redirect_en = 1'b1; redirect_pc = 32'h0000_0100;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++; $display("FAIL b2b_noreq0: imem_req=%b required 0", imem_req);
    end
    step();
    redirect_pc = 32'h0000_0201;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++; $display("FAIL b2b_noreq1: imem_req=%b required 0", imem_req);
    end
    step();
    redirect_en = 1'b0;
    nvalid = 0; first_acc = 1'b1;
    for (int i = 0; i < 30 && nvalid == 0; i++) begin
      step();
      if (acc_seen && first_acc) begin
        first_acc = 1'b0;
        n_checks++;
        if (acc_addr !== 32'h200) begin
          n_fail++; $display("FAIL b2b_addr: first addr=%h required 200", acc_addr);
        end
      end
      if (ins_valid === 1'b1) begin
        nvalid++;
        n_checks++;
        if (pc_fetch_out !== 32'h200 || ins_fetch_out !== word_at(32'h200)) begin
          n_fail++; $display("FAIL b2b_target: ins=%h pc=%h required %h/200", ins_fetch_out, pc_fetch_out, word_at(32'h200));
        end
      end
    end
    n_checks++;
    if (nvalid == 0) begin
      n_fail++; $display("FAIL b2b_timeout: no valid instruction within 30 cycles");
    end
  endtask

  task automatic test_mid_reset();
    int nvalid;
    lat = 3;
    do_reset(2);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if (out_cnt !== 1) begin
      n_fail++; $display("FAIL mid_pre: outstanding=%0d required 1", out_cnt);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++; $display("FAIL mid_req_low: imem_req=%b required 0", imem_req);
    end
    step();
    n_checks++;
    if (ins_valid !== 1'b0 || ins_fetch_out !== NOP || pc_fetch_out !== 32'h0 || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_out: ins=%h pc=%h v=%b req=%b required %h/0/0/0", ins_fetch_out, pc_fetch_out, ins_valid, imem_req, NOP);
    end
    pend_addr.delete(); pend_due.delete(); out_cnt = 0; rv_model = 1'b0;
    rst = 1'b1; stall = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL mid_restart: req=%b addr=%h required 1/0", imem_req, imem_addr);
    end
    nvalid = 0;
    for (int i = 0; i < 20 && nvalid < 2; i++) begin
      step();
      n_checks++;
      if (ins_valid === 1'b1) begin
        if (pc_fetch_out !== 32'(nvalid * 4) || ins_fetch_out !== word_at(32'(nvalid * 4))) begin
          n_fail++;
          $display("FAIL mid_stale: ins=%h pc=%h required %h/%h", ins_fetch_out, pc_fetch_out, word_at(32'(nvalid * 4)), 32'(nvalid * 4));
        end
        nvalid++;
      end else if (ins_fetch_out !== NOP) begin
        n_fail++; $display("FAIL mid_bubble: ins=%h required %h", ins_fetch_out, NOP);
      end
    end
    n_checks++;
    if (nvalid < 2) begin
      n_fail++; $display("FAIL mid_timeout: valid count=%0d required 2", nvalid);
    end
  endtask

  initial begin
    test_reset();
    test_wait_states();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
